// File: rtl/conv_pkg.sv
// Shared definitions for the convolution pass scheduler.
//   - scheduler state encoding (plain constants so older tools can consume it)
//   - fp_width(): total FP word width from exponent/fraction widths
package conv_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_STREAM = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_NEXT   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // sign + exponent + fraction
  function automatic int fp_width(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

endpackage

// File: rtl/conv_pass_scheduler_if.sv
// Window stream / engine handshake bundle between the pass scheduler and
// the convolution engine.
//   pix_valid_i  upstream window valid          (into scheduler)
//   pix_ready_o  scheduler accepts window       (from scheduler)
//   kernel_o     active kernel, [row][col]      (from scheduler)
//   col_o/row_o  pixel coordinate of window     (from scheduler)
//   valid_o      window valid to engine         (from scheduler)
//   eng_valid_i  engine result valid            (into scheduler)
// master = scheduler side, slave = engine/stream side.
interface conv_pass_scheduler_if #(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3
);
  import conv_pkg::*;

  localparam int FP_W = fp_width(EXP_WIDTH, FRAC_WIDTH);

  logic                                               pix_valid_i;
  logic                                               pix_ready_o;
  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_W-1:0] kernel_o;
  logic [15:0]                                        col_o;
  logic [15:0]                                        row_o;
  logic                                               valid_o;
  logic                                               eng_valid_i;

  modport master (
    input  pix_valid_i, eng_valid_i,
    output pix_ready_o, kernel_o, col_o, row_o, valid_o
  );

  modport slave (
    output pix_valid_i, eng_valid_i,
    input  pix_ready_o, kernel_o, col_o, row_o, valid_o
  );

endinterface

// File: rtl/conv_coord_counter.sv
// Raster coordinate generator for one frame.
//   clk_i/rst_i  clock, synchronous active-high reset
//   clr_i        restart at (0,0)
//   adv_i        step to the next pixel (col first, wrap into row)
//   col_o/row_o  current coordinate
//   last_o       current coordinate is the final pixel of the frame
module conv_coord_counter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        adv_i,
  output logic [15:0] col_o,
  output logic [15:0] row_o,
  output logic        last_o
);

  logic col_end;

  assign col_end = (col_o == 16'(IMG_WIDTH - 1));
  assign last_o  = col_end && (row_o == 16'(IMG_HEIGHT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      col_o <= '0;
      row_o <= '0;
    end else if (adv_i) begin
      if (col_end) begin
        col_o <= '0;
        row_o <= last_o ? 16'd0 : row_o + 16'd1;
      end else begin
        col_o <= col_o + 16'd1;
      end
    end
  end

endmodule

// File: rtl/conv_pass_scheduler.sv
// Multi-pass convolution scheduler. Holds NUM_PASSES kernel banks written
// while idle; on start runs num_passes_i passes, each streaming one full
// frame of windows to the engine with the pass's kernel, then waiting for
// IMG_WIDTH*IMG_HEIGHT engine results before moving on.
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_we_i/pass/idx/data  kernel coefficient write (IDLE only)
//   start_i, num_passes_i   sequence start (IDLE only, 1..NUM_PASSES)
//   bus                     window stream / engine handshake (master side)
//   pass_o                  current pass index
//   busy_o                  sequence active
//   pass_done_o, done_o     one-cycle completion pulses
module conv_pass_scheduler
  import conv_pkg::*;
#(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int NUM_PASSES    = 4,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           cfg_we_i,
  input  logic [$clog2(NUM_PASSES)-1:0]                  cfg_pass_i,
  input  logic [$clog2(WINDOW_WIDTH*WINDOW_HEIGHT)-1:0]  cfg_idx_i,
  input  logic [fp_width(EXP_WIDTH, FRAC_WIDTH)-1:0]     cfg_data_i,
  input  logic                                           start_i,
  input  logic [$clog2(NUM_PASSES):0]                    num_passes_i,
  conv_pass_scheduler_if.master                          bus,
  output logic [$clog2(NUM_PASSES)-1:0]                  pass_o,
  output logic                                           busy_o,
  output logic                                           pass_done_o,
  output logic                                           done_o
);

  localparam int K     = WINDOW_WIDTH * WINDOW_HEIGHT;
  localparam int FP_W  = fp_width(EXP_WIDTH, FRAC_WIDTH);
  localparam int PW    = $clog2(NUM_PASSES);
  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);

  state_t                                  state;
  logic [PW:0]                             np_r;
  logic [NUM_PASSES-1:0][K-1:0][FP_W-1:0]  bank;
  logic [CW-1:0]                           res_cnt;

  logic [15:0] c_col, c_row;
  logic        c_last;
  logic        accept, cnt_en, res_full, res_hit;

  assign accept   = (state == ST_STREAM) && bus.pix_valid_i;
  assign cnt_en   = (state == ST_STREAM) || (state == ST_DRAIN);
  assign res_full = (res_cnt == CW'(TOTAL));
  // Includes this cycle's result so DRAIN leaves without an idle cycle.
  assign res_hit  = res_full || (bus.eng_valid_i && res_cnt == CW'(TOTAL - 1));

  assign bus.pix_ready_o = (state == ST_STREAM);
  assign busy_o          = (state != ST_IDLE);
  assign pass_done_o     = (state == ST_NEXT);
  assign done_o          = (state == ST_DONE);

  conv_coord_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_coord (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state == ST_LOAD),
    .adv_i  (accept),
    .col_o  (c_col),
    .row_o  (c_row),
    .last_o (c_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      pass_o       <= '0;
      np_r         <= '0;
      bank         <= '0;
      res_cnt      <= '0;
      bus.kernel_o <= '0;
      bus.valid_o  <= 1'b0;
      bus.col_o    <= '0;
      bus.row_o    <= '0;
    end else begin
      bus.valid_o <= accept;
      if (accept) begin
        bus.col_o <= c_col;
        bus.row_o <= c_row;
      end
      // Saturate so stray results after the frame cannot wrap the count.
      if (cnt_en && bus.eng_valid_i && !res_full)
        res_cnt <= res_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (cfg_we_i && (32'(cfg_idx_i) < K))
            bank[cfg_pass_i][cfg_idx_i] <= cfg_data_i;
          if (start_i && (num_passes_i != '0) &&
              (num_passes_i <= (PW+1)'(NUM_PASSES))) begin
            np_r   <= num_passes_i;
            pass_o <= '0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Bank word k is row-major, matching kernel_o[k/W][k%W].
          bus.kernel_o <= bank[pass_o];
          res_cnt      <= '0;
          state        <= ST_STREAM;
        end
        ST_STREAM: if (accept && c_last) state <= ST_DRAIN;
        ST_DRAIN:  if (res_hit) state <= ST_NEXT;
        ST_NEXT: begin
          if ({1'b0, pass_o} == np_r - 1'b1) begin
            state <= ST_DONE;
          end else begin
            pass_o <= pass_o + 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pass_scheduler.sv
module tb_conv_pass_scheduler;
  localparam int EW = 5, FW = 10, WW = 3, WH = 3, NP = 2, IW = 4, IH = 2;
  localparam int K = WW * WH, PIX = IW * IH;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_we_i = 1'b0;
  logic [0:0]  cfg_pass_i = '0;
  logic [3:0]  cfg_idx_i = '0;
  logic [15:0] cfg_data_i = '0;
  logic        start_i = 1'b0;
  logic [1:0]  num_passes_i = '0;
  logic [0:0]  pass_o;
  logic        busy_o, pass_done_o, done_o;

  conv_pass_scheduler_if #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW),
    .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH)) bus ();

  conv_pass_scheduler #(
    .EXP_WIDTH(EW), .FRAC_WIDTH(FW), .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH),
    .NUM_PASSES(NP), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_pass_i(cfg_pass_i),
    .cfg_idx_i(cfg_idx_i), .cfg_data_i(cfg_data_i), .start_i(start_i),
    .num_passes_i(num_passes_i), .bus(bus), .pass_o(pass_o), .busy_o(busy_o),
    .pass_done_o(pass_done_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct { int col; int row; int pass; } exp_t;
  exp_t        q[$];
  logic [15:0] bank_m [NP][K];
  logic [15:0] centre_seen [NP];
  int vectors = 0, miscompares = 0;
  int pd_seen = 0, done_seen = 0, run_np = 0, last_col = -1, last_row = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare process: every emitted window must be the next raster coordinate
  // of the expected pass, carrying that pass's kernel from the bank model.
  always @(negedge clk) begin
    if (bus.valid_o) begin
      if (q.size() == 0) chk("extra_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("col", bus.col_o, e.col);
        chk("row", bus.row_o, e.row);
        chk("pass", pass_o, e.pass);
        for (int r = 0; r < WH; r++)
          for (int c = 0; c < WW; c++)
            chk("kernel", bus.kernel_o[r][c], bank_m[e.pass][r*WW+c]);
        centre_seen[e.pass] = bus.kernel_o[1][1];
        last_col = bus.col_o;
        last_row = bus.row_o;
      end
    end
    if (pass_done_o) begin
      pd_seen++;
      chk("pass_done_after_frame", q.size(), (run_np - pd_seen) * PIX);
    end
    if (done_o) begin
      done_seen++;
      chk("done_after_passes", pd_seen, run_np);
    end
    if (bus.pix_ready_o) chk("busy_in_stream", busy_o, 1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int p, input int idx, input logic [15:0] d);
    cfg_we_i = 1'b1; cfg_pass_i = 1'(p); cfg_idx_i = 4'(idx); cfg_data_i = d;
    tick();
    cfg_we_i = 1'b0;
    bank_m[p][idx] = d;
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (!bus.pix_ready_o && cyc < 20) begin tick(); cyc++; end
    chk("stream_entry", bus.pix_ready_o, 1);
  endtask

  task automatic feed(input int n, input bit gappy);
    int sent = 0, cyc = 0;
    while (sent < n && cyc < 100) begin
      bus.pix_valid_i = gappy ? (cyc % 2 == 0) : 1'b1;
      if (bus.pix_valid_i && bus.pix_ready_o) sent++;
      tick(); cyc++;
    end
    bus.pix_valid_i = 1'b0;
    chk("feed_count", sent, n);
  endtask

  task automatic eng_stream(input int n);
    int cnt = 0, cyc = 0;
    while (cnt < n && cyc < 100) begin
      bus.eng_valid_i = 1'b1;
      if (bus.pix_ready_o) cnt++;
      tick(); cyc++;
    end
    bus.eng_valid_i = 1'b0;
  endtask

  task automatic eng_pulses(input int n);
    for (int i = 0; i < n; i++) begin bus.eng_valid_i = 1'b1; tick(); end
    bus.eng_valid_i = 1'b0;
  endtask

  task automatic run_seq(input int np, input bit gappy, input bit overlap, input bit poke);
    int cyc;
    pd_seen = 0; done_seen = 0; run_np = np;
    for (int p = 0; p < np; p++)
      for (int i = 0; i < PIX; i++) q.push_back('{i % IW, i / IW, p});
    start_i = 1'b1; num_passes_i = 2'(np);
    tick();
    start_i = 1'b0;
    for (int p = 0; p < np; p++) begin
      wait_ready();
      if (poke && p == 0) begin
        cfg_we_i = 1'b1; cfg_pass_i = 1'b0; cfg_idx_i = 4'd4; cfg_data_i = 16'h1234;
        start_i = 1'b1; num_passes_i = 2'd1;
        tick();
        cfg_we_i = 1'b0; start_i = 1'b0;
      end
      if (overlap) fork feed(PIX, gappy); eng_stream(PIX); join
      else begin feed(PIX, gappy); eng_pulses(PIX); end
      cyc = 0;
      while (pd_seen < p + 1 && cyc < 50) begin tick(); cyc++; end
      chk("pass_done_seen", pd_seen, p + 1);
    end
    cyc = 0;
    while (busy_o && cyc < 20) begin tick(); cyc++; end
    chk("busy_end", busy_o, 0);
    chk("done_count", done_seen, 1);
    chk("pass_done_count", pd_seen, np);
    chk("queue_empty", q.size(), 0);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ready"}, bus.pix_ready_o, 0);
    chk({tag, "_valid"}, bus.valid_o, 0);
    chk({tag, "_col"}, bus.col_o, 0);
    chk({tag, "_row"}, bus.row_o, 0);
    chk({tag, "_pass"}, pass_o, 0);
    chk({tag, "_pdone"}, pass_done_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_kernel"}, (bus.kernel_o == '0), 1);
  endtask

  initial begin
    bus.pix_valid_i = 1'b0;
    bus.eng_valid_i = 1'b0;
    for (int p = 0; p < NP; p++) for (int k = 0; k < K; k++) bank_m[p][k] = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    check_idle_zero("reset");

    // single pass, centre tap 1.0
    wr(0, 4, 16'h3C00);
    run_seq(1, 0, 0, 0);
    chk("p0_centre_lit", centre_seen[0], 16'h3C00);
    chk("last_col_lit", last_col, 3);
    chk("last_row_lit", last_row, 1);

    // two passes, bank1 centre 2.0
    wr(1, 4, 16'h4000);
    run_seq(2, 0, 0, 0);
    chk("p0_centre_2pass", centre_seen[0], 16'h3C00);
    chk("p1_centre_2pass", centre_seen[1], 16'h4000);

    // gappy stream, results arriving during STREAM
    last_col = -1; last_row = -1;
    run_seq(1, 1, 1, 0);
    chk("gappy_last_col", last_col, 3);
    chk("gappy_last_row", last_row, 1);

    // config write and start during STREAM are ignored
    centre_seen[0] = 16'hFFFF;
    run_seq(2, 0, 0, 1);
    chk("poke_centre", centre_seen[0], 16'h3C00);

    // illegal pass counts leave the scheduler idle
    start_i = 1'b1; num_passes_i = 2'd0; tick(); start_i = 1'b0; tick();
    chk("np0_busy", busy_o, 0);
    start_i = 1'b1; num_passes_i = 2'd3; tick(); start_i = 1'b0; tick();
    chk("np3_busy", busy_o, 0);

    // reset while pixel (2,0) is being presented
    run_np = 1; pd_seen = 0;
    for (int i = 0; i < PIX; i++) q.push_back('{i % IW, i / IW, 0});
    start_i = 1'b1; num_passes_i = 2'd1; tick(); start_i = 1'b0;
    wait_ready();
    feed(2, 0);
    rst_i = 1'b1; bus.pix_valid_i = 1'b1;
    tick();
    rst_i = 1'b0; bus.pix_valid_i = 1'b0;
    check_idle_zero("midrst");
    q.delete();
    for (int p = 0; p < NP; p++) for (int k = 0; k < K; k++) bank_m[p][k] = '0;
    centre_seen[0] = 16'hFFFF; centre_seen[1] = 16'hFFFF;
    run_seq(2, 0, 0, 0);
    chk("rst_bank0_zero", centre_seen[0], 16'h0000);
    chk("rst_bank1_zero", centre_seen[1], 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
